// File: rtl/tia_playfield_scan_controller.sv
// Playfield scan controller: holds PF0/PF1/PF2/CTRLPF and walks the 20-bit
// playfield across the 160 visible color clocks of a scanline.
module tia_playfield_scan_controller #(
    parameter int CLKS_PER_BIT = 4,
    parameter int HALF_BITS    = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hblank_end,
    input  logic       wr_en,
    input  logic [5:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       pf_out,
    output logic       pf_active,
    output logic       pf_half,
    output logic [4:0] pf_bit_idx,
    output logic [1:0] pf_color_sel,
    output logic       pf_priority
);

    // state  | meaning
    // IDLE   | outside the visible line, playfield blanked
    // LEFT   | left half, bits shown in index order
    // RIGHT  | right half, order set by reflect_latched
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LEFT  = 2'd1;
    localparam logic [1:0] ST_RIGHT = 2'd2;

    localparam int SUB_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CLKS_PER_BIT - 1);
    localparam logic [4:0]       IDX_LAST = 5'(HALF_BITS - 1);

    localparam logic [5:0] ADDR_CTRLPF = 6'h0A;
    localparam logic [5:0] ADDR_PF0    = 6'h0D;
    localparam logic [5:0] ADDR_PF1    = 6'h0E;
    localparam logic [5:0] ADDR_PF2    = 6'h0F;

    logic [3:0]       pf0_reg;
    logic [7:0]       pf1_reg;
    logic [7:0]       pf2_reg;
    logic             ctrl_reflect;
    logic             ctrl_score;
    logic             ctrl_priority;

    logic [1:0]       state;
    logic [SUB_W-1:0] sub;
    logic [4:0]       idx;
    logic             reflect_latched;

    logic [HALF_BITS-1:0] pf_bits;
    logic                 active;
    logic                 half;
    logic [4:0]           disp_idx;

    // CPU-visible registers; PF0 keeps only its upper nibble (D7..D4 -> [3:0]).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pf0_reg       <= 4'd0;
            pf1_reg       <= 8'd0;
            pf2_reg       <= 8'd0;
            ctrl_reflect  <= 1'b0;
            ctrl_score    <= 1'b0;
            ctrl_priority <= 1'b0;
        end else if (wr_en) begin
            case (wr_addr)
                ADDR_CTRLPF: begin
                    ctrl_reflect  <= wr_data[0];
                    ctrl_score    <= wr_data[1];
                    ctrl_priority <= wr_data[2];
                end
                ADDR_PF0: pf0_reg <= wr_data[7:4];
                ADDR_PF1: pf1_reg <= wr_data;
                ADDR_PF2: pf2_reg <= wr_data;
                default: ;
            endcase
        end
    end

    // hblank_end restarts the line from any state, including the last RIGHT edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            sub             <= '0;
            idx             <= 5'd0;
            reflect_latched <= 1'b0;
        end else if (hblank_end) begin
            state <= ST_LEFT;
            sub   <= '0;
            idx   <= 5'd0;
        end else begin
            case (state)
                ST_LEFT, ST_RIGHT: begin
                    if (sub == SUB_LAST) begin
                        sub <= '0;
                        if (idx == IDX_LAST) begin
                            idx <= 5'd0;
                            if (state == ST_LEFT) begin
                                state           <= ST_RIGHT;
                                reflect_latched <= ctrl_reflect;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            idx <= idx + 5'd1;
                        end
                    end else begin
                        sub <= sub + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    sub   <= '0;
                    idx   <= 5'd0;
                end
            endcase
        end
    end

    // Scan-order bit vector: PF0 D4..D7, PF1 D7..D0, PF2 D0..D7.
    always_comb begin
        pf_bits = '0;
        for (int i = 0; i < 4; i++) begin
            pf_bits[i] = pf0_reg[i];
        end
        for (int i = 0; i < 8; i++) begin
            pf_bits[4 + i]  = pf1_reg[7 - i];
            pf_bits[12 + i] = pf2_reg[i];
        end
    end

    always_comb begin
        active   = (state == ST_LEFT) || (state == ST_RIGHT);
        half     = (state == ST_RIGHT);
        disp_idx = 5'd0;
        if (active) begin
            disp_idx = (half && reflect_latched) ? (IDX_LAST - idx) : idx;
        end
    end

    assign pf_out       = active & pf_bits[disp_idx];
    assign pf_active    = active;
    assign pf_half      = half;
    assign pf_bit_idx   = disp_idx;
    assign pf_color_sel = ctrl_score ? (half ? 2'd2 : 2'd1) : 2'd0;
    assign pf_priority  = ctrl_priority;

endmodule

// File: tb/tb_tia_playfield_scan_controller.sv
// Scoreboard bench for the playfield scan controller: a line-position model
// predicts every output cycle, a monitor compares against the DUT.
module tb_tia_playfield_scan_controller;

    logic       clk;
    logic       rst_n;
    logic       hblank_end;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       pf_out;
    logic       pf_active;
    logic       pf_half;
    logic [4:0] pf_bit_idx;
    logic [1:0] pf_color_sel;
    logic       pf_priority;

    typedef struct packed {
        logic       out;
        logic       active;
        logic       half;
        logic [4:0] idx;
        logic [1:0] sel;
        logic       prio;
    } obs_t;

    int   errors = 0;
    int   checks = 0;
    obs_t exp_q[$];

    // Model: pos = visible clock shown next cycle (-1 when blanked).
    int         pos = -1;
    logic [7:0] m_pf0 = 8'h00;
    logic [7:0] m_pf1 = 8'h00;
    logic [7:0] m_pf2 = 8'h00;
    logic [2:0] m_ctrl = 3'b000;
    logic       m_refl = 1'b0;

    tia_playfield_scan_controller #(.CLKS_PER_BIT(4), .HALF_BITS(20)) dut (
        .clk(clk), .rst_n(rst_n), .hblank_end(hblank_end),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pf_out(pf_out), .pf_active(pf_active), .pf_half(pf_half),
        .pf_bit_idx(pf_bit_idx), .pf_color_sel(pf_color_sel),
        .pf_priority(pf_priority)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic pf_bit(input int n);
        if (n < 4)       return m_pf0[4 + n];
        else if (n < 12) return m_pf1[11 - n];
        else             return m_pf2[n - 12];
    endfunction

    function automatic obs_t predict();
        obs_t e;
        int   n;
        e        = '0;
        e.active = (pos >= 0);
        e.half   = (pos >= 80);
        if (e.active) begin
            n     = (pos % 80) / 4;
            if (e.half && m_refl) n = 19 - n;
            e.idx = 5'(n);
            e.out = pf_bit(n);
        end
        e.sel  = m_ctrl[1] ? (e.half ? 2'd2 : 2'd1) : 2'd0;
        e.prio = m_ctrl[2];
        return e;
    endfunction

    task automatic model_edge(input logic hb, input logic we,
                              input logic [5:0] a, input logic [7:0] d);
        int old_pos;
        old_pos = pos;
        if (hb) pos = 0;
        else if (pos >= 0) begin
            pos = pos + 1;
            if (pos == 160) pos = -1;
        end
        if (!hb && old_pos == 79) m_refl = m_ctrl[0];
        if (we) begin
            case (a)
                6'h0A: m_ctrl = d[2:0];
                6'h0D: m_pf0  = d;
                6'h0E: m_pf1  = d;
                6'h0F: m_pf2  = d;
                default: ;
            endcase
        end
    endtask

    task automatic model_reset();
        pos = -1; m_pf0 = 0; m_pf1 = 0; m_pf2 = 0; m_ctrl = 0; m_refl = 0;
    endtask

    task automatic step(input logic hb, input logic we,
                        input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        hblank_end = hb; wr_en = we; wr_addr = a; wr_data = d;
        @(posedge clk);
        model_edge(hb, we, a, d);
        exp_q.push_back(predict());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 6'h00, 8'h00);
    endtask

    // E0 (hblank_end) then n more edges; optional directed write at edge wc.
    task automatic run_line(input int n, input int wc, input logic [5:0] wa,
                            input logic [7:0] wd, input bit rnd);
        for (int c = 0; c <= n; c++) begin
            logic       we;
            logic [5:0] a;
            logic [7:0] d;
            we = (c == wc); a = wa; d = wd;
            if (rnd && !we && $urandom_range(0, 7) == 0) begin
                we = 1'b1;
                d  = 8'($urandom_range(0, 255));
                case ($urandom_range(0, 4))
                    0: a = 6'h0A;
                    1: a = 6'h0D;
                    2: a = 6'h0E;
                    3: a = 6'h0F;
                    default: a = 6'($urandom_range(0, 63));
                endcase
            end
            step(c == 0, we, a, d);
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        step(1'b0, 1'b1, a, d);
    endtask

    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            obs_t e;
            obs_t g;
            e = exp_q.pop_front();
            g = '{pf_out, pf_active, pf_half, pf_bit_idx, pf_color_sel, pf_priority};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL scan t=%0t got out=%b act=%b half=%b idx=%0d sel=%0d pri=%b want out=%b act=%b half=%b idx=%0d sel=%0d pri=%b",
                         $time, g.out, g.active, g.half, g.idx, g.sel, g.prio,
                         e.out, e.active, e.half, e.idx, e.sel, e.prio);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        obs_t g;
        g = '{pf_out, pf_active, pf_half, pf_bit_idx, pf_color_sel, pf_priority};
        checks++;
        if (g !== '0) begin
            errors++;
            $display("FAIL %s got=%h want=000", tag, g);
        end
    endtask

    initial begin
        rst_n = 1'b0; hblank_end = 1'b0; wr_en = 1'b0;
        wr_addr = 6'h00; wr_data = 8'h00;
        repeat (3) @(negedge clk);
        #1 check_reset_outputs("reset_state");
        rst_n = 1'b1;
        idle(3);

        // Single lit bit 0: cycles 1..4 and 81..84.
        wr(6'h0D, 8'h10);
        run_line(165, -1, 6'h00, 8'h00, 0);

        // Bit 19 with reflect on, then off.
        wr(6'h0D, 8'h00); wr(6'h0F, 8'h80); wr(6'h0A, 8'h01);
        run_line(162, -1, 6'h00, 8'h00, 0);
        wr(6'h0A, 8'h00);
        run_line(162, -1, 6'h00, 8'h00, 0);

        // Score colours, then score off with priority set.
        wr(6'h0E, 8'hFF); wr(6'h0A, 8'h02);
        run_line(162, -1, 6'h00, 8'h00, 0);
        wr(6'h0A, 8'h04);
        run_line(162, -1, 6'h00, 8'h00, 0);

        // Reflect written mid-right-half: takes effect only on the next line.
        wr(6'h0A, 8'h00); wr(6'h0E, 8'h00); wr(6'h0F, 8'h0F);
        run_line(162, 100, 6'h0A, 8'h01, 0);
        run_line(162, -1, 6'h00, 8'h00, 0);

        // PF1 written mid-line while idx 4 displays.
        wr(6'h0A, 8'h00); wr(6'h0F, 8'h00);
        run_line(162, 20, 6'h0E, 8'hFF, 0);

        // Write coincident with hblank_end, and restart on the final RIGHT edge.
        run_line(159, 0, 6'h0D, 8'hA0, 0);
        run_line(159, 0, 6'h0A, 8'h03, 0);
        run_line(163, -1, 6'h00, 8'h00, 0);

        // Randomised lines: full, truncated and back-to-back restarts.
        for (int l = 0; l < 10; l++) begin
            int n;
            case ($urandom_range(0, 3))
                0: n = 159;
                1: n = $urandom_range(60, 158);
                default: n = 160 + $urandom_range(0, 6);
            endcase
            run_line(n, -1, 6'h00, 8'h00, 1);
        end

        // Mid-LEFT reset at cycle 50.
        wr(6'h0E, 8'hFF); wr(6'h0A, 8'h07);
        run_line(49, -1, 6'h00, 8'h00, 0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset_midline");
        model_reset();
        exp_q.delete();
        #1 rst_n = 1'b1;
        idle(20);
        run_line(165, -1, 6'h00, 8'h00, 0);

        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
